serial_adder: RTL and testbench

Multi-cycle, parametrised N-bit adder built around a STEP-bit full-adder slice with a registered carry. Operands are captured on a start pulse. STEP bits are summed per cycle, LSB first, and a one-cycle done pulse is raised when the full result is registered. Trades latency for area; intended for narrow datapaths and control-side arithmetic where a full-width carry chain is not justified.

---
 rtl/serial_adder.sv | 140 ++++++++++++++
 tb/tb_serial_adder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Multi-cycle WIDTH-bit adder, STEP bits per cycle, LSB first.
//            Optional subtract mode when SERIAL_ADDER_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSTEP = WIDTH / STEP;
  localparam int CNT_W = $clog2(NSTEP + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(NSTEP - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  generate
    if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_cfg
      $fatal(1, "serial_adder: WIDTH must be a positive multiple of STEP");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [STEP:0]    w_slice;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; the caller's carry-in is irrelevant then.
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? 1'b1 : cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  assign w_slice = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]}
                 + {{STEP{1'b0}}, r_carry};
  assign w_last  = (r_cnt == c_last);

  generate
    if (STEP == WIDTH) begin : g_res_single
      assign w_res_next = w_slice[STEP-1:0];
    end else begin : g_res_shift
      assign w_res_next = {w_slice[STEP-1:0], r_res[WIDTH-1:STEP]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (start)  w_state_next = c_st_run;
      c_st_run:  if (w_last) w_state_next = c_st_done;
      c_st_done: w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state != c_st_idle);
    done = (r_state == c_st_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_cnt   <= '0;
          end
        end
        c_st_run: begin
          r_a     <= r_a >> STEP;
          r_b     <= r_b >> STEP;
          r_carry <= w_slice[STEP];
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Visible result only changes at the completion edge.
          if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_slice[STEP];
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Scoreboard bench for serial_adder (STEP=1 and STEP=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start8 = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       busy8, done8, cout8, busy4, done4, cout4;
  logic [7:0] sum8, sum4;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t q8[$];
  exp_t q4[$];

  serial_adder #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(8), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        check("dut8 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("dut8 sum",  {24'd0, sum8}, {24'd0, e.s});
        check("dut8 cout", {31'd0, cout8}, {31'd0, e.c});
        check("dut8 done cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        check("dut4 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("dut4 sum",  {24'd0, sum4}, {24'd0, e.s});
        check("dut4 cout", {31'd0, cout4}, {31'd0, e.c});
        check("dut4 done cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle(input bit w4);
    int n = 0;
    while ((w4 ? busy4 : busy8) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("wait idle timeout", 32'd1, 32'd0);
  endtask

  // Issue one operation with its hand-computed result.
  task automatic issue(input bit w4, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic isub,
                       input logic [7:0] es, input logic ec);
    exp_t e;
    wait_idle(w4);
    a = ia; b = ib; cin = ic; sub = isub;
    if (w4) start4 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0;
    e.s = es; e.c = ec; e.cyc = cyc + (w4 ? 2 : 8);
    if (w4) q4.push_back(e); else q8.push_back(e);
  endtask

  initial begin
    int nb;
    // Reset asserted between edges must act immediately.
    #2 rst_n = 1'b0;
    #1;
    check("reset sum",  {24'd0, sum8}, 32'd0);
    check("reset cout", {31'd0, cout8}, 32'd0);
    check("reset busy", {31'd0, busy8}, 32'd0);
    check("reset done", {31'd0, done8}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle outputs", {22'd0, busy8, done8, cout8, sum8}, 32'd0);
    end

    // Basic add with busy length and held previous result.
    issue(1'b0, 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
    @(negedge clk);
    check("sum held during run", {24'd0, sum8}, 32'd0);
    nb = 1;
    for (int i = 0; i < 20 && busy8; i++) begin
      @(negedge clk);
      if (busy8) nb++;
    end
    check("busy cycles", nb, 9);

    // Carry boundaries.
    issue(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    issue(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    issue(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);

    // Start while busy is ignored, operands are not re-sampled.
    issue(1'b0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_idle(1'b0);
    @(negedge clk);
    check("no restart after busy start", {31'd0, busy8}, 32'd0);

    // Reset mid-run aborts with no done and a cleared result.
    wait_idle(1'b0);
    a = 8'h80; b = 8'h80; cin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort sum",  {24'd0, sum8}, 32'd0);
    check("abort cout", {31'd0, cout8}, 32'd0);
    check("abort busy", {31'd0, busy8}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    issue(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

    // STEP=4 instance.
    issue(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
    issue(1'b1, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    issue(1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
`endif

    for (int i = 0; i < 100 && (q8.size() != 0 || q4.size() != 0 || busy8 || busy4); i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    check("dut8 pending results", q8.size(), 32'd0);
    check("dut4 pending results", q4.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
